// File: rtl/ram_responder_pkg.sv
// ============================================================================
// Module  : ram_responder_pkg
// Brief   : Control/status pin positions and FSM encodings for ram_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_responder_pkg;

    localparam int RAM_READ_PIN  = 0;
    localparam int RAM_WRITE_PIN = 1;
    localparam int RAM_ACK       = 0;
    localparam int RAM_ERR       = 1;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_BUSY = 2'd1,
        RS_HOLD = 2'd2
    } rs_state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_BOTH  = 2'd2
    } rs_op_e;

    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_responder_if.sv
// ============================================================================
// Module  : ram_responder_if
// Brief   : Device-bus signals between the mobo sequencer and the RAM device.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ram_responder_if;
    logic [31:0] ram_ctrl;
    logic [31:0] ram_stat;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output ram_ctrl, addr, data_in,
        input  ram_stat, data_out
    );

    modport slave (
        input  ram_ctrl, addr, data_in,
        output ram_stat, data_out
    );
endinterface

`default_nettype wire

// File: rtl/ram_responder_array.sv
// ============================================================================
// Module  : ram_array
// Brief   : Single-port word storage, synchronous write, registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_array #(
    parameter int ADDR_BITS = 12
) (
    input  wire logic                 clk,
    input  wire logic                 we,
    input  wire logic                 re,
    input  wire logic [ADDR_BITS-1:0] a,
    input  wire logic [31:0]          d,
    output logic      [31:0]          q
);

    logic [31:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[a] <= d;
        end
        if (re) begin
            q <= r_mem[a];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
// ============================================================================
// Module  : ram_responder
// Brief   : Four-phase RAM responder: request latch, latency counter, ACK/ERR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ram_responder_if.slave bus
);

    localparam int CNT_W = cnt_width(LATENCY);

    rs_state_e          r_state, w_state_nxt;
    rs_op_e             r_op,    w_op_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [31:0]        r_addr,  w_addr_nxt;
    logic [31:0]        r_data,  w_data_nxt;
    logic               r_ack,   w_ack_nxt;
    logic               r_err,   w_err_nxt;
    logic               r_zero,  w_zero_nxt;
    logic               w_we, w_re, w_rd, w_wr, w_oor;
    logic [31:0]        w_q;
    logic               w_unused;

    assign w_rd     = bus.ram_ctrl[RAM_READ_PIN];
    assign w_wr     = bus.ram_ctrl[RAM_WRITE_PIN];
    assign w_oor    = |(r_addr >> ADDR_BITS);
    assign w_unused = &{1'b0, bus.ram_ctrl};

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        w_zero_nxt  = r_zero;
        w_we        = 1'b0;
        w_re        = 1'b0;
        case (r_state)
            RS_IDLE: begin
                if (w_rd || w_wr) begin
                    w_state_nxt = RS_BUSY;
                    w_addr_nxt  = bus.addr;
                    w_data_nxt  = bus.data_in;
                    w_cnt_nxt   = CNT_W'(LATENCY);
                    w_op_nxt    = (w_rd && w_wr) ? OP_BOTH : (w_rd ? OP_READ : OP_WRITE);
                end
            end
            RS_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = RS_HOLD;
                    w_ack_nxt   = 1'b1;
                    if (r_op == OP_BOTH) begin
                        w_err_nxt = 1'b1;
                    end else if (w_oor) begin
                        // Out-of-range read reports zero instead of stale data.
                        w_err_nxt = 1'b1;
                        if (r_op == OP_READ) begin
                            w_zero_nxt = 1'b1;
                        end
                    end else if (r_op == OP_WRITE) begin
                        w_we = rst;
                    end else begin
                        w_re       = rst;
                        w_zero_nxt = 1'b0;
                    end
                end
            end
            RS_HOLD: begin
                if (!w_rd && !w_wr) begin
                    w_state_nxt = RS_IDLE;
                    w_ack_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RS_IDLE;
            r_op    <= OP_READ;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    ram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram_array (
        .clk (clk),
        .we  (w_we),
        .re  (w_re),
        .a   (r_addr[ADDR_BITS-1:0]),
        .d   (r_data),
        .q   (w_q)
    );

    // The array's read register is not reset, so r_zero masks it until a real read.
    assign bus.data_out = r_zero ? 32'd0 : w_q;

    always_comb begin
        bus.ram_stat          = '0;
        bus.ram_stat[RAM_ACK] = r_ack;
        bus.ram_stat[RAM_ERR] = r_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ============================================================================
// Module  : tb_ram_responder
// Brief   : Scoreboard bench for ram_responder (ADDR_BITS=4, LATENCY=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_responder;
    import ram_responder_pkg::*;

    localparam int ADDR_BITS = 4;
    localparam int LATENCY   = 2;
    localparam logic [31:0] ST_ACK = 32'd1 << RAM_ACK;
    localparam logic [31:0] ST_ERR = 32'd1 << RAM_ERR;

    typedef struct {
        logic [31:0] stat;
        logic [31:0] dout;
    } exp_t;

    logic clk;
    logic rst;
    ram_responder_if bus_if();

    exp_t        sb_q[$];
    logic [31:0] model_mem [2**ADDR_BITS];
    logic [31:0] model_dout;
    int          n_cmp;
    int          n_bad;

    ram_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LATENCY   (LATENCY)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit chg);
        exp_t        e;
        exp_t        got;
        logic [31:0] c;
        int          cyc;
        bit          seen;
        bit          oor;
        oor = (a >= 32'(2**ADDR_BITS));
        e.stat = ST_ACK;
        if (rd && wr) begin
            e.stat |= ST_ERR;
        end else if (oor) begin
            e.stat |= ST_ERR;
            if (rd) model_dout = 32'd0;
        end else if (wr) begin
            model_mem[a[ADDR_BITS-1:0]] = d;
        end else begin
            model_dout = model_mem[a[ADDR_BITS-1:0]];
        end
        e.dout = model_dout;
        sb_q.push_back(e);

        c = '0;
        c[RAM_READ_PIN]  = rd;
        c[RAM_WRITE_PIN] = wr;
        bus_if.ram_ctrl = c;
        bus_if.addr     = a;
        bus_if.data_in  = d;
        tick();
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (chg && cyc == 1) begin
                bus_if.addr    = 32'd9;
                bus_if.data_in = $urandom;
            end
            tick();
            cyc++;
            seen = bus_if.ram_stat[RAM_ACK];
        end
        got = sb_q.pop_front();
        if (!seen) begin
            check_eq("ack_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("ack_latency", 32'(cyc), 32'(LATENCY + 1));
            check_eq("ack_stat", bus_if.ram_stat, got.stat);
            check_eq("ack_dout", bus_if.data_out, got.dout);
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 2) bus_if.addr = 32'd0;
            tick();
            check_eq("hold_stat", bus_if.ram_stat, got.stat);
            check_eq("hold_dout", bus_if.data_out, got.dout);
        end
        bus_if.ram_ctrl = '0;
        tick();
        check_eq("ack_drop", bus_if.ram_stat, 32'd0);
    endtask

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        model_dout      = 32'd0;
        rst             = 1'b0;
        bus_if.ram_ctrl = '0;
        bus_if.addr     = '0;
        bus_if.data_in  = '0;

        for (int i = 0; i < 3; i++) begin
            bus_if.ram_ctrl = $urandom;
            bus_if.addr     = $urandom;
            bus_if.data_in  = $urandom;
            tick();
            check_eq("rst_stat", bus_if.ram_stat, 32'd0);
            check_eq("rst_dout", bus_if.data_out, 32'd0);
        end
        bus_if.ram_ctrl = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_no_ack", bus_if.ram_stat, 32'd0);
        end

        req(1'b0, 1'b1, 32'd9, 32'h1111_2222, 0, 1'b0);
        req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0, 1'b0);
        req(1'b1, 1'b0, 32'd5, 32'h0,         10, 1'b1);
        req(1'b1, 1'b0, 32'd9, 32'h0,         0, 1'b0);

        req(1'b0, 1'b1, 32'd0,  32'hCAFE_0000, 0, 1'b0);
        req(1'b0, 1'b1, 32'd16, 32'h0000_1234, 0, 1'b0);
        req(1'b1, 1'b0, 32'd0,  32'h0,         0, 1'b0);
        req(1'b1, 1'b0, 32'd16, 32'h0,         0, 1'b0);

        req(1'b1, 1'b0, 32'd5, 32'h0,         0, 1'b0);
        req(1'b1, 1'b1, 32'd5, 32'h0000_0077, 0, 1'b0);
        req(1'b1, 1'b0, 32'd5, 32'h0,         0, 1'b0);

        req(1'b0, 1'b1, 32'd3, 32'hA5A5_A5A5, 0, 1'b0);
        bus_if.ram_ctrl = 32'd1 << RAM_WRITE_PIN;
        bus_if.addr     = 32'd3;
        bus_if.data_in  = 32'h0000_0055;
        tick();
        tick();
        rst             = 1'b0;
        bus_if.ram_ctrl = '0;
        tick();
        model_dout = 32'd0;
        check_eq("midrst_stat", bus_if.ram_stat, 32'd0);
        check_eq("midrst_dout", bus_if.data_out, 32'd0);
        rst = 1'b1;
        tick();
        check_eq("midrst_idle", bus_if.ram_stat, 32'd0);
        req(1'b1, 1'b0, 32'd3, 32'h0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
